// File: rtl/aludec_pipe.sv
// ALU-control decoder with registered ID/EX boundary, reserved-funct flag,
// mul/div latency counter driving an E-stall request and a HI/LO hazard flag.

package aludec_pipe_pkg;
  localparam logic [3:0] R_TYPE_OP = 4'd0;
  localparam logic [3:0] ANDI_OP   = 4'd1;
  localparam logic [3:0] ORI_OP    = 4'd2;
  localparam logic [3:0] XORI_OP   = 4'd3;
  localparam logic [3:0] LUI_OP    = 4'd4;
  localparam logic [3:0] ADDI_OP   = 4'd5;
  localparam logic [3:0] ADDIU_OP  = 4'd6;
  localparam logic [3:0] SLTI_OP   = 4'd7;
  localparam logic [3:0] SLTIU_OP  = 4'd8;
  localparam logic [3:0] MFC0_OP   = 4'd9;
  localparam logic [3:0] MTC0_OP   = 4'd10;

  localparam logic [4:0] AND_CONTROL   = 5'd1;
  localparam logic [4:0] OR_CONTROL    = 5'd2;
  localparam logic [4:0] XOR_CONTROL   = 5'd3;
  localparam logic [4:0] NOR_CONTROL   = 5'd4;
  localparam logic [4:0] LUI_CONTROL   = 5'd5;
  localparam logic [4:0] ADD_CONTROL   = 5'd6;
  localparam logic [4:0] ADDU_CONTROL  = 5'd7;
  localparam logic [4:0] SUB_CONTROL   = 5'd8;
  localparam logic [4:0] SUBU_CONTROL  = 5'd9;
  localparam logic [4:0] SLT_CONTROL   = 5'd10;
  localparam logic [4:0] SLTU_CONTROL  = 5'd11;
  localparam logic [4:0] SLL_CONTROL   = 5'd12;
  localparam logic [4:0] SRL_CONTROL   = 5'd13;
  localparam logic [4:0] SRA_CONTROL   = 5'd14;
  localparam logic [4:0] SLLV_CONTROL  = 5'd15;
  localparam logic [4:0] SRLV_CONTROL  = 5'd16;
  localparam logic [4:0] SRAV_CONTROL  = 5'd17;
  localparam logic [4:0] MFHI_CONTROL  = 5'd18;
  localparam logic [4:0] MFLO_CONTROL  = 5'd19;
  localparam logic [4:0] MTHI_CONTROL  = 5'd20;
  localparam logic [4:0] MTLO_CONTROL  = 5'd21;
  localparam logic [4:0] MULT_CONTROL  = 5'd22;
  localparam logic [4:0] MULTU_CONTROL = 5'd23;
  localparam logic [4:0] DIV_CONTROL   = 5'd24;
  localparam logic [4:0] DIVU_CONTROL  = 5'd25;
  localparam logic [4:0] MFC0_CONTROL  = 5'd26;
  localparam logic [4:0] MTC0_CONTROL  = 5'd27;

  localparam logic [5:0] SLL_FUNCT   = 6'b000000;
  localparam logic [5:0] SRL_FUNCT   = 6'b000010;
  localparam logic [5:0] SRA_FUNCT   = 6'b000011;
  localparam logic [5:0] SLLV_FUNCT  = 6'b000100;
  localparam logic [5:0] SRLV_FUNCT  = 6'b000110;
  localparam logic [5:0] SRAV_FUNCT  = 6'b000111;
  localparam logic [5:0] MFHI_FUNCT  = 6'b010000;
  localparam logic [5:0] MTHI_FUNCT  = 6'b010001;
  localparam logic [5:0] MFLO_FUNCT  = 6'b010010;
  localparam logic [5:0] MTLO_FUNCT  = 6'b010011;
  localparam logic [5:0] MULT_FUNCT  = 6'b011000;
  localparam logic [5:0] MULTU_FUNCT = 6'b011001;
  localparam logic [5:0] DIV_FUNCT   = 6'b011010;
  localparam logic [5:0] DIVU_FUNCT  = 6'b011011;
  localparam logic [5:0] ADD_FUNCT   = 6'b100000;
  localparam logic [5:0] ADDU_FUNCT  = 6'b100001;
  localparam logic [5:0] SUB_FUNCT   = 6'b100010;
  localparam logic [5:0] SUBU_FUNCT  = 6'b100011;
  localparam logic [5:0] AND_FUNCT   = 6'b100100;
  localparam logic [5:0] OR_FUNCT    = 6'b100101;
  localparam logic [5:0] XOR_FUNCT   = 6'b100110;
  localparam logic [5:0] NOR_FUNCT   = 6'b100111;
  localparam logic [5:0] SLT_FUNCT   = 6'b101010;
  localparam logic [5:0] SLTU_FUNCT  = 6'b101011;
endpackage

module aludec_pipe #(
  parameter int OP_W    = 4,
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instrD,
  input  logic [OP_W-1:0]   aluopD,
  input  logic              validD,
  input  logic              stallE,
  input  logic              flushE,
  output logic [CTRL_W-1:0] alucontrolE,
  output logic              validE,
  output logic              riE,
  output logic              md_stall_req,
  output logic              md_doneE,
  output logic              hilo_hazardD
);
  import aludec_pipe_pkg::*;

  localparam logic [7:0] MUL_INIT = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_INIT = 8'(DIV_LAT - 1);

  logic [5:0]        w_funct;
  logic [4:0]        w_ctrl;
  logic              w_riD;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_is_hilo;
  logic              w_busy;
  logic              w_load;
  logic              w_unused;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_valid;
  logic              r_ri;
  logic [7:0]        r_cnt;
  logic              r_done;

  assign w_funct  = instrD[5:0];
  assign w_unused = ^instrD[31:6];

  always_comb begin
    w_ctrl = '0;
    w_riD  = 1'b0;
    if (validD) begin
      case (aluopD)
        OP_W'(ANDI_OP):  w_ctrl = AND_CONTROL;
        OP_W'(ORI_OP):   w_ctrl = OR_CONTROL;
        OP_W'(XORI_OP):  w_ctrl = XOR_CONTROL;
        OP_W'(LUI_OP):   w_ctrl = LUI_CONTROL;
        OP_W'(ADDI_OP):  w_ctrl = ADD_CONTROL;
        OP_W'(ADDIU_OP): w_ctrl = ADDU_CONTROL;
        OP_W'(SLTI_OP):  w_ctrl = SLT_CONTROL;
        OP_W'(SLTIU_OP): w_ctrl = SLTU_CONTROL;
        OP_W'(MFC0_OP):  w_ctrl = MFC0_CONTROL;
        OP_W'(MTC0_OP):  w_ctrl = MTC0_CONTROL;
        OP_W'(R_TYPE_OP): begin
          case (w_funct)
            AND_FUNCT:   w_ctrl = AND_CONTROL;
            OR_FUNCT:    w_ctrl = OR_CONTROL;
            XOR_FUNCT:   w_ctrl = XOR_CONTROL;
            NOR_FUNCT:   w_ctrl = NOR_CONTROL;
            SLL_FUNCT:   w_ctrl = SLL_CONTROL;
            SRL_FUNCT:   w_ctrl = SRL_CONTROL;
            SRA_FUNCT:   w_ctrl = SRA_CONTROL;
            SLLV_FUNCT:  w_ctrl = SLLV_CONTROL;
            SRLV_FUNCT:  w_ctrl = SRLV_CONTROL;
            SRAV_FUNCT:  w_ctrl = SRAV_CONTROL;
            MFHI_FUNCT:  w_ctrl = MFHI_CONTROL;
            MFLO_FUNCT:  w_ctrl = MFLO_CONTROL;
            MTHI_FUNCT:  w_ctrl = MTHI_CONTROL;
            MTLO_FUNCT:  w_ctrl = MTLO_CONTROL;
            ADD_FUNCT:   w_ctrl = ADD_CONTROL;
            ADDU_FUNCT:  w_ctrl = ADDU_CONTROL;
            SUB_FUNCT:   w_ctrl = SUB_CONTROL;
            SUBU_FUNCT:  w_ctrl = SUBU_CONTROL;
            SLT_FUNCT:   w_ctrl = SLT_CONTROL;
            SLTU_FUNCT:  w_ctrl = SLTU_CONTROL;
            MULT_FUNCT:  w_ctrl = MULT_CONTROL;
            MULTU_FUNCT: w_ctrl = MULTU_CONTROL;
            DIV_FUNCT:   w_ctrl = DIV_CONTROL;
            DIVU_FUNCT:  w_ctrl = DIVU_CONTROL;
            default:     w_riD  = 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign w_is_mul  = (w_ctrl == MULT_CONTROL) || (w_ctrl == MULTU_CONTROL);
  assign w_is_div  = (w_ctrl == DIV_CONTROL)  || (w_ctrl == DIVU_CONTROL);
  assign w_is_hilo = (w_ctrl == MFHI_CONTROL) || (w_ctrl == MFLO_CONTROL) ||
                     (w_ctrl == MTHI_CONTROL) || (w_ctrl == MTLO_CONTROL);

  // Stall request depends on the counter alone, never on stallE/flushE.
  assign w_busy       = (r_cnt != '0);
  assign md_stall_req = w_busy;
  assign w_load       = !flushE && !stallE && !w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_ri    <= 1'b0;
    end else if (flushE) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_ri    <= 1'b0;
    end else if (w_load) begin
      r_ctrl  <= CTRL_W'(w_ctrl);
      r_valid <= validD;
      r_ri    <= w_riD;
    end
  end

  // A unit latency never raises busy, so its done pulse is issued at load time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (flushE) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (w_busy) begin
      r_cnt  <= r_cnt - 8'd1;
      r_done <= (r_cnt == 8'd1);
    end else if (w_load && w_is_mul) begin
      r_cnt  <= MUL_INIT;
      r_done <= (MUL_LAT == 1);
    end else if (w_load && w_is_div) begin
      r_cnt  <= DIV_INIT;
      r_done <= (DIV_LAT == 1);
    end else begin
      r_done <= 1'b0;
    end
  end

  assign alucontrolE  = r_ctrl;
  assign validE       = r_valid;
  assign riE          = r_ri;
  assign md_doneE     = r_done;
  assign hilo_hazardD = validD && w_is_hilo && (w_busy || r_done);

endmodule

// File: tb/tb_aludec_pipe.sv
// Bench for aludec_pipe: two instances (different latencies) share stimulus and
// are compared each cycle against a timestamp-based reference model.
module tb_aludec_pipe;
  import aludec_pipe_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instrD;
  logic [3:0]       aluopD;
  logic             validD;
  logic             stallE;
  logic             flushE;
  logic [1:0][4:0]  ctrlE;
  logic [1:0]       validE;
  logic [1:0]       riE;
  logic [1:0]       stall_req;
  logic [1:0]       doneE;
  logic [1:0]       hazD;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  aludec_pipe #(.OP_W(4), .CTRL_W(5), .MUL_LAT(1), .DIV_LAT(36)) u_dut0 (
    .clk(clk), .rst(rst), .instrD(instrD), .aluopD(aluopD), .validD(validD),
    .stallE(stallE), .flushE(flushE), .alucontrolE(ctrlE[0]), .validE(validE[0]),
    .riE(riE[0]), .md_stall_req(stall_req[0]), .md_doneE(doneE[0]),
    .hilo_hazardD(hazD[0])
  );

  aludec_pipe #(.OP_W(4), .CTRL_W(5), .MUL_LAT(4), .DIV_LAT(5)) u_dut1 (
    .clk(clk), .rst(rst), .instrD(instrD), .aluopD(aluopD), .validD(validD),
    .stallE(stallE), .flushE(flushE), .alucontrolE(ctrlE[1]), .validE(validE[1]),
    .riE(riE[1]), .md_stall_req(stall_req[1]), .md_doneE(doneE[1]),
    .hilo_hazardD(hazD[1])
  );

  // Decode reference tables
  logic [5:0] fn_tab[24] = '{AND_FUNCT, OR_FUNCT, XOR_FUNCT, NOR_FUNCT, SLL_FUNCT,
    SRL_FUNCT, SRA_FUNCT, SLLV_FUNCT, SRLV_FUNCT, SRAV_FUNCT, MFHI_FUNCT, MFLO_FUNCT,
    MTHI_FUNCT, MTLO_FUNCT, ADD_FUNCT, ADDU_FUNCT, SUB_FUNCT, SUBU_FUNCT, SLT_FUNCT,
    SLTU_FUNCT, MULT_FUNCT, MULTU_FUNCT, DIV_FUNCT, DIVU_FUNCT};
  logic [4:0] fc_tab[24] = '{AND_CONTROL, OR_CONTROL, XOR_CONTROL, NOR_CONTROL,
    SLL_CONTROL, SRL_CONTROL, SRA_CONTROL, SLLV_CONTROL, SRLV_CONTROL, SRAV_CONTROL,
    MFHI_CONTROL, MFLO_CONTROL, MTHI_CONTROL, MTLO_CONTROL, ADD_CONTROL, ADDU_CONTROL,
    SUB_CONTROL, SUBU_CONTROL, SLT_CONTROL, SLTU_CONTROL, MULT_CONTROL, MULTU_CONTROL,
    DIV_CONTROL, DIVU_CONTROL};
  logic [3:0] op_tab[10] = '{ANDI_OP, ORI_OP, XORI_OP, LUI_OP, ADDI_OP, ADDIU_OP,
    SLTI_OP, SLTIU_OP, MFC0_OP, MTC0_OP};
  logic [4:0] oc_tab[10] = '{AND_CONTROL, OR_CONTROL, XOR_CONTROL, LUI_CONTROL,
    ADD_CONTROL, ADDU_CONTROL, SLT_CONTROL, SLTU_CONTROL, MFC0_CONTROL, MTC0_CONTROL};

  // Model state: E contents plus absolute cycle stamps of the mul/div window
  int m_ctrl[2];
  bit m_valid[2];
  bit m_ri[2];
  int stall_end[2];
  int done_cyc[2];
  int lat_mul[2] = '{1, 4};
  int lat_div[2] = '{36, 5};

  function automatic void decode_ref(input logic [3:0] op, input logic [5:0] f,
                                     input logic v, output int ctrl, output bit ri);
    ctrl = 0;
    ri   = 1'b0;
    if (v) begin
      if (op == R_TYPE_OP) begin
        ri = 1'b1;
        for (int i = 0; i < 24; i++)
          if (fn_tab[i] == f) begin
            ctrl = int'(fc_tab[i]);
            ri   = 1'b0;
          end
      end else begin
        for (int i = 0; i < 10; i++)
          if (op_tab[i] == op) ctrl = int'(oc_tab[i]);
      end
    end
  endfunction

  function automatic bit is_hilo(input int c);
    return c == int'(MFHI_CONTROL) || c == int'(MFLO_CONTROL) ||
           c == int'(MTHI_CONTROL) || c == int'(MTLO_CONTROL);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ctrl[d]    = 0;
      m_valid[d]   = 1'b0;
      m_ri[d]      = 1'b0;
      stall_end[d] = -1;
      done_cyc[d]  = -1;
    end
  endtask

  function automatic bit m_busy(input int d);
    return cyc <= stall_end[d];
  endfunction

  task automatic check_outputs();
    int  ctrl;
    bit  ri;
    bit  busy;
    bit  done;
    decode_ref(aluopD, instrD[5:0], validD, ctrl, ri);
    for (int d = 0; d < 2; d++) begin
      busy = m_busy(d);
      done = (cyc == done_cyc[d]);
      check($sformatf("d%0d.ctrlE", d), 32'(ctrlE[d]), 32'(m_ctrl[d]));
      check($sformatf("d%0d.validE", d), 32'(validE[d]), 32'(m_valid[d]));
      check($sformatf("d%0d.riE", d), 32'(riE[d]), 32'(m_ri[d]));
      check($sformatf("d%0d.stall_req", d), 32'(stall_req[d]), 32'(busy));
      check($sformatf("d%0d.doneE", d), 32'(doneE[d]), 32'(done));
      check($sformatf("d%0d.hazD", d), 32'(hazD[d]),
            32'(validD && is_hilo(ctrl) && (busy || done)));
    end
  endtask

  // Check at negedge, then advance the model across the next rising edge.
  task automatic cycle();
    int n_ctrl[2];
    bit n_valid[2];
    bit n_ri[2];
    int n_se[2];
    int n_dc[2];
    int ctrl;
    bit ri;
    int lat;
    @(negedge clk);
    check_outputs();
    decode_ref(aluopD, instrD[5:0], validD, ctrl, ri);
    for (int d = 0; d < 2; d++) begin
      n_ctrl[d] = m_ctrl[d]; n_valid[d] = m_valid[d]; n_ri[d] = m_ri[d];
      n_se[d] = stall_end[d]; n_dc[d] = done_cyc[d];
      if (rst || flushE) begin
        n_ctrl[d] = 0; n_valid[d] = 1'b0; n_ri[d] = 1'b0;
        n_se[d] = -1; n_dc[d] = -1;
      end else if (!stallE && !m_busy(d)) begin
        n_ctrl[d] = ctrl; n_valid[d] = validD; n_ri[d] = ri;
        lat = 0;
        if (ctrl == int'(MULT_CONTROL) || ctrl == int'(MULTU_CONTROL)) lat = lat_mul[d];
        if (ctrl == int'(DIV_CONTROL) || ctrl == int'(DIVU_CONTROL)) lat = lat_div[d];
        if (lat != 0) begin
          n_se[d] = cyc + lat - 1;
          n_dc[d] = cyc + lat;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_ctrl[d] = n_ctrl[d]; m_valid[d] = n_valid[d]; m_ri[d] = n_ri[d];
      stall_end[d] = n_se[d]; done_cyc[d] = n_dc[d];
    end
    cyc++;
  endtask

  task automatic drive(input logic [3:0] op, input logic [5:0] f, input logic v,
                       input logic st, input logic fl);
    aluopD = op;
    instrD = {$urandom_range(0, 67108863), f};
    validD = v;
    stallE = st;
    flushE = fl;
  endtask

  task automatic settle();
    drive(4'd15, 6'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (!m_busy(0) && !m_busy(1) && done_cyc[0] < cyc && done_cyc[1] < cyc) break;
      cycle();
    end
    cycle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_st;
    int n_dn;
    int dn_at;
    int hz;
    logic [4:0] c35;
    logic [4:0] c36;

    rst = 1'b1;
    model_reset();
    drive(4'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // ADDI, then async reset asserted mid-cycle
    drive(ADDI_OP, 6'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("addi.ctrl", 32'(ctrlE[0]), 32'(ADD_CONTROL));
    check("addi.valid", 32'(validE[0]), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst.ctrl", 32'(ctrlE[0]), 32'd0);
    check("rst.valid", 32'(validE[0]), 32'd0);
    check_outputs();
    drive(4'd15, 6'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    rst = 1'b0;
    cycle();

    // R-type sweep
    for (int i = 0; i < 24; i++) begin
      drive(R_TYPE_OP, fn_tab[i], 1'b1, 1'b0, 1'b0);
      cycle();
      check($sformatf("sweep%0d", i), 32'(ctrlE[0]), 32'(fc_tab[i]));
      settle();
    end
    drive(R_TYPE_OP, 6'b111111, 1'b1, 1'b0, 1'b0);
    cycle();
    check("resv.ctrl", 32'(ctrlE[0]), 32'd0);
    check("resv.ri", 32'(riE[0]), 32'd1);
    settle();

    // DIV with ADDU waiting in D
    drive(R_TYPE_OP, DIV_FUNCT, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(R_TYPE_OP, ADDU_FUNCT, 1'b1, 1'b0, 1'b0);
    n_st = 0; n_dn = 0; dn_at = -1; c35 = '0; c36 = '0;
    for (int k = 0; k < 45; k++) begin
      n_st += int'(stall_req[0]);
      if (doneE[0]) begin n_dn++; dn_at = k; end
      if (k == 35) c35 = ctrlE[0];
      if (k == 36) c36 = ctrlE[0];
      cycle();
    end
    check("div.stall_cycles", 32'(n_st), 32'd35);
    check("div.done_count", 32'(n_dn), 32'd1);
    check("div.done_at", 32'(dn_at), 32'd35);
    check("div.hold", 32'(c35), 32'(DIV_CONTROL));
    check("div.next", 32'(c36), 32'(ADDU_CONTROL));
    settle();

    // MULT: latency 1 on dut0, latency 4 on dut1
    drive(R_TYPE_OP, MULT_FUNCT, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(4'd15, 6'd0, 1'b0, 1'b0, 1'b0);
    n_st = 0; dn_at = -1; hz = 0;
    for (int k = 0; k < 10; k++) begin
      n_st += int'(stall_req[1]);
      hz   += int'(stall_req[0]);
      if (doneE[1]) dn_at = k;
      if (k == 0) check("mul1.done", 32'(doneE[0]), 32'd1);
      cycle();
    end
    check("mul1.stalls", 32'(hz), 32'd0);
    check("mul4.stalls", 32'(n_st), 32'd3);
    check("mul4.done_at", 32'(dn_at), 32'd3);
    settle();

    // Flush at countdown cycle 10, then a fresh DIV
    drive(R_TYPE_OP, DIV_FUNCT, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(4'd15, 6'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cycle();
    flushE = 1'b1;
    cycle();
    flushE = 1'b0;
    check("flush.stall", 32'(stall_req[0]), 32'd0);
    check("flush.valid", 32'(validE[0]), 32'd0);
    check("flush.ctrl", 32'(ctrlE[0]), 32'd0);
    n_dn = 0;
    for (int k = 0; k < 40; k++) begin
      n_dn += int'(doneE[0]);
      cycle();
    end
    check("flush.no_done", 32'(n_dn), 32'd0);
    drive(R_TYPE_OP, DIVU_FUNCT, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(4'd15, 6'd0, 1'b0, 1'b0, 1'b0);
    n_st = 0;
    for (int k = 0; k < 40; k++) begin
      n_st += int'(stall_req[0]);
      cycle();
    end
    check("reload.stalls", 32'(n_st), 32'd35);
    settle();

    // Hazard: MFLO in D during divide, stallE pulses sprinkled in
    drive(R_TYPE_OP, DIV_FUNCT, 1'b1, 1'b0, 1'b0);
    cycle();
    hz = 0; n_st = 0; n_dn = 0;
    for (int k = 0; k < 45; k++) begin
      drive(R_TYPE_OP, MFLO_FUNCT, 1'b1, (k % 7 == 3), 1'b0);
      #1;
      hz   += int'(hazD[0]);
      n_st += int'(stall_req[0]);
      n_dn += int'(doneE[0]);
      cycle();
    end
    check("haz.cycles", 32'(hz), 32'd36);
    check("haz.stalls", 32'(n_st), 32'd35);
    check("haz.done", 32'(n_dn), 32'd1);
    settle();
    drive(R_TYPE_OP, DIV_FUNCT, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(R_TYPE_OP, MFLO_FUNCT, 1'b0, 1'b0, 1'b0);
    #1;
    check("haz.invalid", 32'(hazD[0]), 32'd0);
    for (int k = 0; k < 10; k++) cycle();
    settle();

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      logic [3:0] op;
      logic [5:0] f;
      int r;
      r  = $urandom_range(0, 99);
      op = (r < 50) ? R_TYPE_OP : (r < 92) ? op_tab[$urandom_range(0, 9)]
                                           : 4'($urandom_range(11, 15));
      f  = ($urandom_range(0, 9) < 8) ? fn_tab[$urandom_range(0, 23)]
                                      : 6'($urandom_range(0, 63));
      drive(op, f, ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 3));
      if ($urandom_range(0, 999) < 3) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      cycle();
    end
    rst = 1'b0;
    settle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
